// File: rtl/seq_mult.sv
// Sequential shift-and-add unsigned multiplier: N-bit operands, 2N-bit product after N cycles,
// with an overflow flag when the product does not fit back into N bits.
module seq_mult #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done,
    output logic           overflow
);

    localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [2*N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]  product_q, product_d;
    logic            overflow_q, overflow_d;
    logic [2*N-1:0]  acc_sum;
    logic            last_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    // Partial sum for this step; on the last step it is the final product.
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (cnt_q == CntW'(N - 1));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = {{N{1'b0}}, multiplicand};
                    mplier_d = multiplier;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (last_step) begin
                    cnt_d      = '0;
                    product_d  = acc_sum;
                    overflow_d = |acc_sum[2*N-1:N];
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign product  = product_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == StCalc);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed cases plus randomized operands checked against
// plain integer multiplication.
module tb_seq_mult;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;
    logic           overflow;

    int vectors;
    int miscompares;

    seq_mult #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned multiply; overflow when the result needs more than N bits.
    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[2*N-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
        return (int'(a) * int'(b)) >= (1 << N);
    endfunction

    // Called at a negedge: pulses start for one cycle, then scrambles the operand bus.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = N'($urandom);
        multiplier   = N'($urandom);
    endtask

    // Advances by negedges until done is seen or the budget runs out.
    task automatic wait_done(output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({product, busy, done, overflow} !== {{(2*N){1'b0}}, 3'b000}) begin
            miscompares++;
            $display("FAIL reset: product=%0d busy=%b done=%b ovf=%b, want all 0",
                     product, busy, done, overflow);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] as [4] = '{4'd3, 4'd15, 4'd6, 4'd0};
        logic [N-1:0] bs [4] = '{4'd5, 4'd15, 4'd7, 4'd9};
        int  bc;
        bit  seen;
        for (int i = 0; i < 4; i++) begin
            issue(as[i], bs[i]);
            wait_done(bc, seen);
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL dir_timeout %0d*%0d: no done within budget", as[i], bs[i]);
            end
            vectors++;
            if (bc != N) begin
                miscompares++;
                $display("FAIL dir_latency %0d*%0d: busy %0d cycles, want %0d",
                         as[i], bs[i], bc, N);
            end
            vectors++;
            if (product !== ref_prod(as[i], bs[i]) || overflow !== ref_ovf(as[i], bs[i])) begin
                miscompares++;
                $display("FAIL dir_result %0d*%0d: product=%0d ovf=%b, want %0d ovf=%b",
                         as[i], bs[i], product, overflow,
                         ref_prod(as[i], bs[i]), ref_ovf(as[i], bs[i]));
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL dir_pulse %0d*%0d: done=%b busy=%b after pulse, want 0 0",
                         as[i], bs[i], done, busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        int bc;
        bit seen;
        int pulses;
        issue(4'd2, 4'd3);
        start = 1'b1;
        multiplicand = 4'd15;
        multiplier = 4'd15;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL ign_timeout: no done within budget");
        end
        // Start while in DONE must also be dropped.
        start = 1'b1;
        multiplicand = 4'd15;
        multiplier = 4'd15;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_done_start: busy=%b after start in DONE, want 0", busy);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL ign_extra_done: %0d extra done pulses, want 0", pulses);
        end
        vectors++;
        if (product !== 8'd6 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_result: product=%0d ovf=%b, want 6 ovf=0", product, overflow);
        end
    endtask

    task automatic test_async_reset();
        int bc;
        bit seen;
        int pulses;
        issue(4'd7, 4'd7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({product, busy, done, overflow} !== {{(2*N){1'b0}}, 3'b000}) begin
            miscompares++;
            $display("FAIL async_reset: product=%0d busy=%b done=%b ovf=%b, want all 0",
                     product, busy, done, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL async_quiet: %0d busy/done cycles after reset, want 0", pulses);
        end
        issue(4'd4, 4'd4);
        wait_done(bc, seen);
        vectors++;
        if (!seen || product !== 8'd16 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL async_restart: seen=%b product=%0d ovf=%b, want 1 16 ovf=1",
                     seen, product, overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a, b;
        logic [2*N-1:0] prev;
        int bc;
        bit seen;
        prev = product;
        for (int i = 0; i < 6; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            issue(a, b);
            // Previous result must stay visible until this operation finishes.
            vectors++;
            if (product !== prev) begin
                miscompares++;
                $display("FAIL b2b_hold %0d: product=%0d during calc, want %0d", i, product, prev);
            end
            wait_done(bc, seen);
            vectors++;
            if (!seen || bc != N || product !== ref_prod(a, b) || overflow !== ref_ovf(a, b)) begin
                miscompares++;
                $display("FAIL b2b %0d*%0d: seen=%b busy=%0d product=%0d ovf=%b, want 1 %0d %0d %b",
                         a, b, seen, bc, product, overflow, N, ref_prod(a, b), ref_ovf(a, b));
            end
            prev = ref_prod(a, b);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        int bc;
        bit seen;
        for (int i = 0; i < 40; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(a, b);
            wait_done(bc, seen);
            vectors++;
            if (!seen || bc != N || product !== ref_prod(a, b) || overflow !== ref_ovf(a, b)) begin
                miscompares++;
                $display("FAIL rand %0d*%0d: seen=%b busy=%0d product=%0d ovf=%b, want 1 %0d %0d %b",
                         a, b, seen, bc, product, overflow, N, ref_prod(a, b), ref_ovf(a, b));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
